fir_tap_line: RTL and testbench
===============================

# fir_tap_line

Multi-channel, handshaked tap delay line feeding the FIR multiply-accumulate stage. Each accepted sample is shifted into the delay line of its own channel. A registered parallel snapshot of that channel's taps is then presented downstream with valid/ready flow control. The block supports a runtime-selectable active tap count (unused taps read as zero), per-channel fill tracking and a global flush, so one instance serves several interleaved sample streams of different filter lengths.

## Interface
Parameters:
- DATA_WIDTH, 16: sample width in bits.
- NUM_TAPS, 8: maximum delay-line depth per channel; must be ≥ 2.
- NUM_CH, 2: number of independent channels; must be ≥ 1.
- CH_W, max(1, $clog2(NUM_CH)): channel-index width.
- CNT_W, $clog2(NUM_TAPS+1): width of tap-count fields.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_WIDTH  sample value.
- in_ch  in  CH_W  channel of the sample.
- active_taps  in  CNT_W  runtime filter length; sampled at each accept.
- flush  in  1  clears all delay lines and fill counters.
- out_valid  out  1  snapshot valid.
- out_ready  in  1  downstream consumes the snapshot.
- out_ch  out  CH_W  channel of the snapshot.
- out_taps  out  NUM_TAPS x DATA_WIDTH  unpacked array [0:NUM_TAPS-1]; index 0 is the newest sample.
- out_primed  out  1  the channel had received ≥ effective active_taps samples since reset or flush, counting this one.
- err_bad_ch  out  1  one-cycle pulse when a sample with in_ch ≥ NUM_CH is accepted.

## Operation
- Storage: NUM_CH delay lines of NUM_TAPS entries each, plus one saturating fill counter per channel (0..NUM_TAPS).
- Accept: an accept occurs when in_valid && in_ready.
- in_ready: equals !rst && !flush && (!out_valid || out_ready), computed combinationally. The block has a single output register and no skid buffer.
- Effective tap count: eff = min(active_taps, NUM_TAPS).
- Accept with a valid channel c:
  - Shift: line[c][i] <= line[c][i-1] for i = NUM_TAPS-1..1, and line[c][0] <= in_data.
  - fill[c] <= min(fill[c]+1, NUM_TAPS).
  - Other channels are untouched.
- Snapshot on the same edge:
  - out_taps[0] <= in_data.
  - out_taps[i] <= line[c][i-1] for 1 ≤ i < eff.
  - out_taps[i] <= 0 for i ≥ eff. This includes tap 0 when eff = 0.
  - out_ch <= c; out_valid <= 1.
  - out_primed <= (min(fill[c]+1, NUM_TAPS) ≥ eff). With eff = 0 the channel is always primed.
- Masking applies only to the output; stored line contents are never masked. Raising active_taps later exposes the true history.
- Accept with in_ch ≥ NUM_CH:
  - The sample is consumed and no line or counter changes.
  - The output register is not loaded; out_valid <= 0 if out_ready, else hold.
  - err_bad_ch <= 1 for one cycle.
- Downstream transfer: out_valid && out_ready.
  - Transfer without a new accept: out_valid <= 0. out_taps, out_ch and out_primed hold their last values.
  - Transfer with a new accept in the same cycle: the new snapshot loads and out_valid stays 1 (back-to-back throughput of one sample per cycle).
- out_valid && !out_ready: all outputs hold stable and in_ready = 0.
- Flush (flush high):
  - All line entries <= 0 and all fill counters <= 0.
  - in_ready = 0, so no sample is taken in a flush cycle.
  - The output register and out_valid are unaffected; a pending snapshot remains deliverable.

## Timing
- Reset (rst high at an edge) sets: all lines and counters 0, out_valid 0, out_taps all 0, out_ch 0, out_primed 0, err_bad_ch 0. in_ready is 0 while rst is high.
- Reset mid-operation discards any pending snapshot without a handshake.
- Latency: accept at edge N puts the snapshot on the outputs after edge N, where it is visible for the cycle N to N+1.
- err_bad_ch is high only in the cycle after the offending accept.
- Fill counters saturate at NUM_TAPS and never wrap.
- Simultaneous flush and rst: rst dominates; the result is identical to reset alone.

## Test plan
- Single channel, NUM_TAPS=8, active_taps=8, samples 1..10 each consumed immediately:
  - After sample 10, out_taps = {10,9,8,7,6,5,4,3,2,1}[0:7], i.e. [10,9,8,7,6,5,4,3].
  - out_primed is first 1 on sample 8.
- Interleave ch0 = 100,101,102 and ch1 = 200,201:
  - The ch1 snapshot shows [201,200,0,…].
  - The next ch0 sample 103 shows [103,102,101,100,0,…] with out_ch = 0.
- active_taps=3 after 6 samples (1..6):
  - Sample 7 yields [7,6,5,0,0,0,0,0].
  - Setting active_taps=8 then sample 8 yields [8,7,6,5,4,3,2,1].
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1:
  - in_ready is 0 throughout.
  - The snapshot is stable and no sample is lost.
  - Releasing out_ready gives one transfer per cycle.
- Flush asserted while out_valid=1 with out_ready=0:
  - The pending snapshot is still delivered unchanged.
  - The next accept of value 5 yields [5,0,…,0] with out_primed = 0 (active_taps=8).
- NUM_CH=3, in_ch=3:
  - The sample is consumed and err_bad_ch pulses once.
  - out_valid does not rise and all lines are unchanged.
  - Mid-stream rst zeros every output next cycle.

Source files
------------

// File: rtl/fir_tap_line.sv
// fir_tap_line: multi-channel tap delay line for the FIR MAC stage.
// Each accepted sample shifts into its channel's delay line. A registered
// snapshot of that channel's taps is offered downstream with valid/ready.
// Taps at or beyond the runtime active_taps are zeroed on the output only.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   upstream handshake; in_data sample, in_ch channel
//   active_taps      filter length, sampled at each accept
//   flush            clears all delay lines and fill counters
//   out_valid/ready  downstream handshake
//   out_ch           channel of the snapshot
//   out_taps         snapshot, index 0 = newest sample
//   out_primed       channel had seen >= effective tap count samples
//   err_bad_ch       one-cycle pulse after accepting an out-of-range channel

// One channel: shift register of NUM_TAPS samples plus a saturating fill count.
module fir_tap_chan #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int CNT_W      = $clog2(NUM_TAPS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 shift,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  taps,
  output logic [CNT_W-1:0]                     fill
);
  localparam logic [CNT_W-1:0] NT_C = CNT_W'(NUM_TAPS);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      taps <= '0;
      fill <= '0;
    end else if (shift) begin
      // element 0 is the newest; older samples move to higher indices
      taps <= {taps[NUM_TAPS-2:0], din};
      if (fill != NT_C) fill <= fill + CNT_W'(1);
    end
  end
endmodule

module fir_tap_line #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W      = $clog2(NUM_TAPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [CNT_W-1:0]      active_taps,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [DATA_WIDTH-1:0] out_taps [0:NUM_TAPS-1],
  output logic                  out_primed,
  output logic                  err_bad_ch
);
  localparam logic [CNT_W-1:0] NT_C  = CNT_W'(NUM_TAPS);
  // one extra bit so NUM_CH itself is representable for the range check
  localparam logic [CH_W:0]    NCH_C = NUM_CH[CH_W:0];

  logic [NUM_CH-1:0][NUM_TAPS-1:0][DATA_WIDTH-1:0] lines;
  logic [NUM_CH-1:0][CNT_W-1:0]                    fills;

  logic                                acc, ch_ok, acc_good;
  logic [CH_W-1:0]                     sel_ch;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] sel_line;
  logic [CNT_W-1:0]                    sel_fill_nxt, eff;

  // single output register, no skid: accept only when the slot is free
  // or being drained this cycle
  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < NCH_C;
  assign acc_good = acc && ch_ok;
  assign sel_ch   = ch_ok ? in_ch : '0;
  assign sel_line = lines[sel_ch];
  assign sel_fill_nxt = (fills[sel_ch] == NT_C) ? NT_C : fills[sel_ch] + CNT_W'(1);
  assign eff      = (active_taps > NT_C) ? NT_C : active_taps;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fir_tap_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_TAPS   (NUM_TAPS),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .shift (acc_good && (in_ch == CH_W'(g))),
      .din   (in_data),
      .taps  (lines[g]),
      .fill  (fills[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_primed <= 1'b0;
      err_bad_ch <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) out_taps[i] <= '0;
    end else begin
      err_bad_ch <= acc && !ch_ok;
      if (acc_good) begin
        // snapshot uses pre-shift line contents: line[i-1] becomes tap i
        out_valid  <= 1'b1;
        out_ch     <= in_ch;
        out_primed <= sel_fill_nxt >= eff;
        out_taps[0] <= (eff != '0) ? in_data : '0;
        for (int i = 1; i < NUM_TAPS; i++)
          out_taps[i] <= (CNT_W'(i) < eff) ? sel_line[i-1] : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_tap_line.sv
module tb_fir_tap_line;
  localparam int DW = 16, NT = 8, NC = 3, CW = 2, CNW = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready, out_primed, err_bad_ch;
  logic [DW-1:0]  in_data;
  logic [CW-1:0]  in_ch, out_ch;
  logic [CNW-1:0] active_taps;
  logic [DW-1:0]  out_taps [0:NT-1];

  fir_tap_line #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .active_taps(active_taps), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_taps(out_taps), .out_primed(out_primed), .err_bad_ch(err_bad_ch));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // reference model: per-channel history, newest first, at most NT kept
  int         hist [NC][$];
  int         m_taps [NT];
  logic       m_valid, m_primed, m_err, m_ready;
  int         m_ch;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) hist[c].delete();
    for (int i = 0; i < NT; i++) m_taps[i] = 0;
    m_valid = 0; m_primed = 0; m_err = 0; m_ch = 0; m_ready = 0;
  endfunction

  function automatic logic [NT*DW-1:0] pack_out();
    logic [NT*DW-1:0] v;
    for (int i = 0; i < NT; i++) v[i*DW +: DW] = out_taps[i];
    return v;
  endfunction

  function automatic logic [NT*DW-1:0] pack_int(input int a [NT]);
    logic [NT*DW-1:0] v;
    for (int i = 0; i < NT; i++) v[i*DW +: DW] = a[i][DW-1:0];
    return v;
  endfunction

  // one clock: drive inputs at negedge, advance model at posedge, return #1 later
  task automatic step(input logic v, input int ch, input int d, input int at,
                      input logic fl, input logic ordy);
    int   eff;
    logic acc;
    @(negedge clk);
    in_valid = v; in_ch = ch[CW-1:0]; in_data = d[DW-1:0];
    active_taps = at[CNW-1:0]; flush = fl; out_ready = ordy;
    acc = v && !fl && (!m_valid || ordy);
    @(posedge clk);
    eff   = (at > NT) ? NT : at;
    m_err = acc && (ch >= NC);
    if (acc && ch < NC) begin
      hist[ch].push_front(d & 16'hffff);
      if (hist[ch].size() > NT) void'(hist[ch].pop_back());
      for (int i = 0; i < NT; i++)
        m_taps[i] = (i < eff && i < hist[ch].size()) ? hist[ch][i] : 0;
      m_ch = ch; m_valid = 1; m_primed = (hist[ch].size() >= eff);
    end else if (ordy) begin
      m_valid = 0;
    end
    if (fl) for (int c = 0; c < NC; c++) hist[c].delete();
    m_ready = !fl && (!m_valid || ordy);
    #1;
  endtask

  task automatic do_flush();
    step(0, 0, 0, 8, 1, 1);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; flush = 0; out_ready = 1; in_ch = 0; in_data = 16'h1234;
    active_taps = 8;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if ({out_ch, out_primed, err_bad_ch} !== '0) begin n_err++;
      $display("FAIL reset_ctl got ch=%0d primed=%b err=%b exp 0", out_ch, out_primed, err_bad_ch); end
    n_cmp++; if (pack_out() !== '0) begin n_err++; $display("FAIL reset_taps got=%h exp=0", pack_out()); end
    in_valid = 0;
    @(negedge clk); rst = 0;
    model_reset();
  endtask

  task automatic test_fill();
    int e [NT];
    do_flush();
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, k, 8, 0, 1);
      n_cmp++; if (out_primed !== (k >= 8)) begin n_err++;
        $display("FAIL fill_primed k=%0d got=%b exp=%b", k, out_primed, (k >= 8)); end
      n_cmp++; if (out_valid !== 1'b1 || out_taps[0] !== DW'(k)) begin n_err++;
        $display("FAIL fill_snap k=%0d got v=%b t0=%0d exp v=1 t0=%0d", k, out_valid, out_taps[0], k); end
    end
    e = '{10, 9, 8, 7, 6, 5, 4, 3};
    n_cmp++; if (pack_out() !== pack_int(e)) begin n_err++;
      $display("FAIL fill_taps got=%h exp=%h", pack_out(), pack_int(e)); end
  endtask

  task automatic test_interleave();
    int e [NT];
    do_flush();
    step(1, 0, 100, 8, 0, 1); step(1, 1, 200, 8, 0, 1);
    step(1, 0, 101, 8, 0, 1); step(1, 1, 201, 8, 0, 1);
    e = '{201, 200, 0, 0, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e) || out_ch !== 2'd1) begin n_err++;
      $display("FAIL ilv_ch1 got ch=%0d taps=%h exp ch=1 taps=%h", out_ch, pack_out(), pack_int(e)); end
    step(1, 0, 102, 8, 0, 1); step(1, 0, 103, 8, 0, 1);
    e = '{103, 102, 101, 100, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e) || out_ch !== 2'd0) begin n_err++;
      $display("FAIL ilv_ch0 got ch=%0d taps=%h exp ch=0 taps=%h", out_ch, pack_out(), pack_int(e)); end
  endtask

  task automatic test_active_taps();
    int e [NT];
    do_flush();
    for (int k = 1; k <= 6; k++) step(1, 0, k, 8, 0, 1);
    step(1, 0, 7, 3, 0, 1);
    e = '{7, 6, 5, 0, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e) || out_primed !== 1'b1) begin n_err++;
      $display("FAIL act3 got taps=%h p=%b exp taps=%h p=1", pack_out(), out_primed, pack_int(e)); end
    step(1, 0, 8, 8, 0, 1);
    e = '{8, 7, 6, 5, 4, 3, 2, 1};
    n_cmp++; if (pack_out() !== pack_int(e) || out_primed !== 1'b1) begin n_err++;
      $display("FAIL act8 got taps=%h p=%b exp taps=%h p=1", pack_out(), out_primed, pack_int(e)); end
    // eff = 0: every tap masked, channel always primed
    step(1, 1, 55, 0, 0, 1);
    n_cmp++; if (pack_out() !== '0 || out_primed !== 1'b1) begin n_err++;
      $display("FAIL act0 got taps=%h p=%b exp taps=0 p=1", pack_out(), out_primed); end
  endtask

  task automatic test_backpressure();
    int e [NT];
    do_flush();
    step(1, 0, 1, 8, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 2, 8, 0, 0);
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_taps[0] !== 16'd1) begin n_err++;
        $display("FAIL bp_hold k=%0d got rdy=%b v=%b t0=%0d exp rdy=0 v=1 t0=1", k, in_ready, out_valid, out_taps[0]); end
    end
    for (int k = 2; k <= 4; k++) begin
      step(1, 0, k, 8, 0, 1);
      n_cmp++; if (out_valid !== 1'b1 || out_taps[0] !== DW'(k) || in_ready !== 1'b1) begin n_err++;
        $display("FAIL bp_b2b k=%0d got v=%b t0=%0d rdy=%b exp v=1 t0=%0d rdy=1", k, out_valid, out_taps[0], in_ready, k); end
    end
    e = '{4, 3, 2, 1, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e)) begin n_err++;
      $display("FAIL bp_taps got=%h exp=%h", pack_out(), pack_int(e)); end
  endtask

  task automatic test_flush();
    int e [NT];
    do_flush();
    step(1, 0, 9, 8, 0, 0);
    step(1, 0, 11, 8, 1, 0);
    e = '{9, 0, 0, 0, 0, 0, 0, 0};
    n_cmp++; if (out_valid !== 1'b1 || pack_out() !== pack_int(e) || in_ready !== 1'b0) begin n_err++;
      $display("FAIL flush_pending got v=%b rdy=%b taps=%h exp v=1 rdy=0 taps=%h", out_valid, in_ready, pack_out(), pack_int(e)); end
    step(0, 0, 0, 8, 0, 1);
    n_cmp++; if (out_valid !== 1'b0 || pack_out() !== pack_int(e)) begin n_err++;
      $display("FAIL flush_deliver got v=%b taps=%h exp v=0 taps=%h", out_valid, pack_out(), pack_int(e)); end
    step(1, 0, 5, 8, 0, 1);
    e = '{5, 0, 0, 0, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e) || out_primed !== 1'b0) begin n_err++;
      $display("FAIL flush_after got taps=%h p=%b exp taps=%h p=0", pack_out(), out_primed, pack_int(e)); end
  endtask

  task automatic test_bad_ch();
    int e [NT];
    do_flush();
    step(1, 2, 40, 8, 0, 1);
    step(0, 0, 0, 8, 0, 1);
    step(1, 3, 77, 8, 0, 1);
    n_cmp++; if (err_bad_ch !== 1'b1 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL bad_pulse got err=%b v=%b exp err=1 v=0", err_bad_ch, out_valid); end
    step(0, 0, 0, 8, 0, 1);
    n_cmp++; if (err_bad_ch !== 1'b0) begin n_err++; $display("FAIL bad_once got err=%b exp=0", err_bad_ch); end
    step(1, 2, 41, 8, 0, 1);
    e = '{41, 40, 0, 0, 0, 0, 0, 0};
    n_cmp++; if (pack_out() !== pack_int(e) || out_ch !== 2'd2) begin n_err++;
      $display("FAIL bad_lines got ch=%0d taps=%h exp ch=2 taps=%h", out_ch, pack_out(), pack_int(e)); end
  endtask

  task automatic test_mid_reset();
    step(1, 1, 33, 5, 0, 0);
    @(negedge clk);
    rst = 1; flush = 1; in_valid = 1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || pack_out() !== '0 || out_ch !== '0 || out_primed !== 1'b0
                 || err_bad_ch !== 1'b0 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL midrst got v=%b ch=%0d p=%b err=%b rdy=%b taps=%h exp all 0",
               out_valid, out_ch, out_primed, err_bad_ch, in_ready, pack_out()); end
    @(negedge clk); rst = 0; flush = 0; in_valid = 0;
    model_reset();
    step(1, 1, 34, 8, 0, 1);
    n_cmp++; if (out_taps[0] !== 16'd34 || out_taps[1] !== 16'd0) begin n_err++;
      $display("FAIL midrst_clear got t0=%0d t1=%0d exp 34 0", out_taps[0], out_taps[1]); end
  endtask

  task automatic test_random();
    int r, ch;
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 9);
      ch = (r == 9) ? 3 : r % 3;
      step($urandom_range(0, 3) != 0, ch, $urandom_range(0, 65535), $urandom_range(0, 15),
           $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
      n_cmp++; if (in_ready !== m_ready || out_valid !== m_valid || err_bad_ch !== m_err) begin n_err++;
        $display("FAIL rnd_ctl n=%0d got rdy=%b v=%b err=%b exp rdy=%b v=%b err=%b",
                 n, in_ready, out_valid, err_bad_ch, m_ready, m_valid, m_err); end
      n_cmp++; if (pack_out() !== pack_int(m_taps) || out_ch !== m_ch[CW-1:0] || out_primed !== m_primed) begin n_err++;
        $display("FAIL rnd_snap n=%0d got ch=%0d p=%b taps=%h exp ch=%0d p=%b taps=%h",
                 n, out_ch, out_primed, pack_out(), m_ch, m_primed, pack_int(m_taps)); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_interleave();
    test_active_taps();
    test_backpressure();
    test_flush();
    test_bad_ch();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
